// File: rtl/multdiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_seq
// Description : Multicycle signed multiply / divide unit for the execute
//               stage. Multiply uses radix-2 Booth recoding, one add/sub and
//               arithmetic shift per cycle. Divide runs non-restoring
//               division on operand magnitudes, then fixes up the sign.
//               A start pulse latches operands; the result and exception
//               flag are valid during a one-cycle data_resultRDY pulse
//               WIDTH+1 cycles later.
// Ports       : clock, ctrl_reset (sync, active-high)
//               data_operandA/B  - multiplicand/dividend, multiplier/divisor
//               ctrl_MULT/DIV    - start pulses (MULT wins if both high)
//               data_result      - low WIDTH bits of product, or quotient
//               data_exception   - mult overflow / div-by-zero / div overflow
//               data_resultRDY   - one-cycle result-valid pulse
// Options     : MULTDIV_EARLY_ZERO_EN - finish trivially-zero operations
//               one cycle after start instead of after WIDTH+1 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module multdiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_MUL  = 2'd1;
    localparam logic [1:0] c_ST_DIV  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] c_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH:0]   r_prod;     // {upper, multiplier, booth bit}
    logic [WIDTH-1:0]   r_addend;   // multiplicand, or |divisor|
    logic [WIDTH:0]     r_rem;      // signed partial remainder
    logic [WIDTH-1:0]   r_quo;      // dividend bits shifting out, quotient in
    logic               r_neg;
    logic               r_div_zero;
    logic               r_div_ovf;
    logic [WIDTH-1:0]   r_result;
    logic               r_exc;
    logic               r_rdy;

    logic               w_start;
    logic               w_early;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_upper;
    logic [WIDTH:0]     w_ext_mcand;
    logic [WIDTH:0]     w_bsum;
    logic [2*WIDTH:0]   w_prod_next;
    logic [WIDTH+1:0]   w_r_shift;
    logic [WIDTH+1:0]   w_dvsr_ext;
    logic [WIDTH+1:0]   w_r_new;
    logic [WIDTH-1:0]   w_quo_next;
    logic [WIDTH-1:0]   w_quo_signed;
    logic               w_mul_ovf;

    assign w_start = ctrl_MULT | ctrl_DIV;
    assign w_abs_a = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    assign w_abs_b = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

`ifdef MULTDIV_EARLY_ZERO_EN
    // A zero product or zero dividend needs no iterations. Divide-by-zero is
    // deliberately excluded so it keeps the normal latency.
    assign w_early = ctrl_MULT ? ((data_operandA == '0) || (data_operandB == '0))
                               : (ctrl_DIV && (data_operandA == '0) && (data_operandB != '0));
`else
    assign w_early = 1'b0;
`endif

    // Booth step. The add/sub is done one bit wider than the operand so that
    // subtracting the most negative multiplicand cannot wrap; the shifted
    // partial product always fits back into the register.
    assign w_upper     = {r_prod[2*WIDTH], r_prod[2*WIDTH:WIDTH+1]};
    assign w_ext_mcand = {r_addend[WIDTH-1], r_addend};

    always_comb begin
        w_bsum = w_upper;
        case (r_prod[1:0])
            2'b01:   w_bsum = w_upper + w_ext_mcand;
            2'b10:   w_bsum = w_upper - w_ext_mcand;
            default: w_bsum = w_upper;
        endcase
    end

    assign w_prod_next = {w_bsum, r_prod[WIDTH:1]};
    // Product bits [2W-1:W-1] live at register bits [2W:W].
    assign w_mul_ovf   = ~((&w_prod_next[2*WIDTH:WIDTH]) | ~(|w_prod_next[2*WIDTH:WIDTH]));

    // Non-restoring step: shift {rem, quo} left, then subtract the divisor
    // when the remainder was non-negative, add it back otherwise. The new
    // quotient bit is the inverted sign of the new remainder, so the
    // quotient register holds the exact magnitude quotient at the end; only
    // the (discarded) remainder would need the final correction.
    assign w_r_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_dvsr_ext   = {2'b00, r_addend};
    assign w_r_new      = r_rem[WIDTH] ? (w_r_shift + w_dvsr_ext) : (w_r_shift - w_dvsr_ext);
    assign w_quo_next   = {r_quo[WIDTH-2:0], ~w_r_new[WIDTH+1]};
    assign w_quo_signed = r_neg ? (~w_quo_next + 1'b1) : w_quo_next;

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_prod     <= '0;
            r_addend   <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_neg      <= 1'b0;
            r_div_zero <= 1'b0;
            r_div_ovf  <= 1'b0;
            r_result   <= '0;
            r_exc      <= 1'b0;
            r_rdy      <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            if (w_start) begin
                // A start in any state (including mid-operation) restarts.
                r_cnt <= CNT_W'(1);
                if (ctrl_MULT) begin
                    r_prod   <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
                    r_addend <= data_operandA;
                    r_state  <= c_ST_MUL;
                end else begin
                    r_rem      <= '0;
                    r_quo      <= w_abs_a;
                    r_addend   <= w_abs_b;
                    r_neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    r_div_zero <= (data_operandB == '0);
                    r_div_ovf  <= (data_operandA == c_MIN) && (&data_operandB);
                    r_state    <= c_ST_DIV;
                end
                if (w_early) begin
                    r_state  <= c_ST_DONE;
                    r_result <= '0;
                    r_exc    <= 1'b0;
                    r_rdy    <= 1'b1;
                end
            end else begin
                case (r_state)
                    c_ST_MUL: begin
                        r_prod <= w_prod_next;
                        r_cnt  <= r_cnt + 1'b1;
                        if (r_cnt == c_LAST) begin
                            r_state  <= c_ST_DONE;
                            r_result <= w_prod_next[WIDTH:1];
                            r_exc    <= w_mul_ovf;
                            r_rdy    <= 1'b1;
                        end
                    end
                    c_ST_DIV: begin
                        r_rem <= w_r_new[WIDTH:0];
                        r_quo <= w_quo_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_LAST) begin
                            r_state  <= c_ST_DONE;
                            // MIN / -1 naturally yields MIN here; only the
                            // flag needs raising.
                            r_result <= r_div_zero ? '0 : w_quo_signed;
                            r_exc    <= r_div_zero | r_div_ovf;
                            r_rdy    <= 1'b1;
                        end
                    end
                    c_ST_DONE: begin
                        r_state <= c_ST_IDLE;
                        r_cnt   <= '0;
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;

endmodule
`default_nettype wire
